// File: rtl/dodge_game_ctrl.sv
// -----------------------------------------------------------------------------
// dodge_game_ctrl
// Game sequencer for the dodgeball VGA game. Divides the system clock into a
// game tick, runs the IDLE/PLAY/OVER state machine, moves the player column
// from the left/right buttons, schedules three falling obstacles per wave,
// detects collisions and keeps the score of completed waves.
//
// Ports
//   CLK_in    in   1        system clock
//   RST_BTN   in   1        asynchronous active-low reset
//   START     in   1        start game (level, sampled on tick)
//   restart   in   1        return to IDLE (level, sampled on tick)
//   left      in   1        move-left button (asynchronous)
//   right     in   1        move-right button (asynchronous)
//   tick_o    out  1        one-cycle game tick strobe
//   state     out  2        0 IDLE, 1 PLAY, 2 OVER
//   player_x  out  4        player column
//   ob_x      out  12       obstacle columns {ob3,ob2,ob1}
//   ob_y      out  12       obstacle rows {ob3,ob2,ob1}, 0..12
//   score     out  SCORE_W  completed waves in the current game
// -----------------------------------------------------------------------------
module dodge_game_ctrl #(
  parameter int TICK_DIV   = 4194304,
  parameter int COLS       = 16,
  parameter int PLAYER_ROW = 10,
  parameter int WAVE_LEN   = 20,
  parameter int SCORE_W    = 8
) (
  input  logic               CLK_in,
  input  logic               RST_BTN,
  input  logic               START,
  input  logic               restart,
  input  logic               left,
  input  logic               right,
  output logic               tick_o,
  output logic [1:0]         state,
  output logic [3:0]         player_x,
  output logic [11:0]        ob_x,
  output logic [11:0]        ob_y,
  output logic [SCORE_W-1:0] score
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]       COL_MAX  = 4'(COLS - 1);
  localparam logic [3:0]       ROW_HIT  = 4'(PLAYER_ROW);
  localparam logic [4:0]       J_LAST   = 5'(WAVE_LEN);
  localparam logic [3:0]       PX_HOME  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       j;
  logic [7:0]       lfsr;
  // [0],[1] form the synchroniser, [2] holds the previous synchronised level
  logic [2:0]       l_sync;
  logic [2:0]       r_sync;
  logic             l_edge;
  logic             r_edge;
  logic             hit;
  logic [11:0]      ob_y_step;

  assign state  = st;
  assign tick_o = (cnt == CNT_LAST);
  assign l_edge = l_sync[1] & ~l_sync[2];
  assign r_edge = r_sync[1] & ~r_sync[2];

  // Collision uses the registered positions, i.e. the values before this
  // tick's update, so a row-10 obstacle is caught before it moves on.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ob_x[4*k +: 4] == player_x && ob_y[4*k +: 4] == ROW_HIT) hit = 1'b1;
    end
  end

  // Each obstacle falls during its own window of wave phases; windows are
  // 12 phases long so the row never exceeds 12.
  always_comb begin
    ob_y_step = ob_y;
    if (j >= 5'd1 && j <= 5'd12)  ob_y_step[3:0]  = ob_y[3:0]  + 4'd1;
    if (j >= 5'd4 && j <= 5'd15)  ob_y_step[7:4]  = ob_y[7:4]  + 4'd1;
    if (j >= 5'd8 && j <= 5'd19)  ob_y_step[11:8] = ob_y[11:8] + 4'd1;
  end

  always_ff @(posedge CLK_in or negedge RST_BTN) begin
    if (!RST_BTN) begin
      cnt      <= '0;
      st       <= S_IDLE;
      player_x <= PX_HOME;
      ob_x     <= 12'h741;
      ob_y     <= '0;
      j        <= '0;
      score    <= '0;
      lfsr     <= 8'hA5;
      l_sync   <= '0;
      r_sync   <= '0;
    end else begin
      cnt    <= tick_o ? '0 : cnt + CNT_W'(1);
      // x^8+x^6+x^5+x^4+1, shifting towards the MSB
      lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      l_sync <= {l_sync[1:0], left};
      r_sync <= {r_sync[1:0], right};

      // Button moves are free-running in PLAY; a tick that leaves PLAY
      // (restart or collision) wins over a move in the same cycle.
      if (st == S_PLAY && !(tick_o && (restart || hit))) begin
        if (l_edge && !r_edge && player_x != 4'd0)
          player_x <= player_x - 4'd1;
        else if (r_edge && !l_edge && player_x != COL_MAX)
          player_x <= player_x + 4'd1;
      end

      if (tick_o) begin
        case (st)
          S_IDLE: begin
            if (START) begin
              st    <= S_PLAY;
              score <= '0;
            end
          end
          S_PLAY: begin
            if (restart) begin
              st       <= S_IDLE;
              j        <= '0;
              ob_y     <= '0;
              player_x <= PX_HOME;
            end else if (hit) begin
              st <= S_OVER;
            end else if (j == J_LAST) begin
              j    <= '0;
              ob_y <= '0;
              if (score != '1) score <= score + SCORE_W'(1);
              ob_x <= {lfsr[3:0] ^ lfsr[7:4], lfsr[7:4], lfsr[3:0]};
            end else begin
              j    <= j + 5'd1;
              ob_y <= ob_y_step;
            end
          end
          S_OVER: begin
            if (restart) begin
              st       <= S_IDLE;
              j        <= '0;
              ob_y     <= '0;
              player_x <= PX_HOME;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dodge_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dodge_game_ctrl
// Self-checking bench for dodge_game_ctrl with TICK_DIV=4. Two instances share
// clock, reset and inputs: dut uses the normal player row, dut_nc uses row 13
// (never reached) so long survival runs need no dodging.
// -----------------------------------------------------------------------------
module tb_dodge_game_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        restart;
  logic        left;
  logic        right;

  logic        tick_a,  tick_b;
  logic [1:0]  state_a, state_b;
  logic [3:0]  px_a,    px_b;
  logic [11:0] obx_a,   obx_b;
  logic [11:0] oby_a,   oby_b;
  logic [7:0]  score_a, score_b;

  dodge_game_ctrl #(
    .TICK_DIV(4), .COLS(16), .PLAYER_ROW(10), .WAVE_LEN(20), .SCORE_W(8)
  ) dut (
    .CLK_in(clk), .RST_BTN(rst_n), .START(start), .restart(restart),
    .left(left), .right(right), .tick_o(tick_a), .state(state_a),
    .player_x(px_a), .ob_x(obx_a), .ob_y(oby_a), .score(score_a)
  );

  dodge_game_ctrl #(
    .TICK_DIV(4), .COLS(16), .PLAYER_ROW(13), .WAVE_LEN(20), .SCORE_W(8)
  ) dut_nc (
    .CLK_in(clk), .RST_BTN(rst_n), .START(start), .restart(restart),
    .left(left), .right(right), .tick_o(tick_b), .state(state_b),
    .player_x(px_b), .ob_x(obx_b), .ob_y(oby_b), .score(score_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR built from the polynomial, reset and clocked like the game.
  logic [7:0] m_lfsr;
  logic [7:0] tick_lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic       l;
    logic       r;
    logic [3:0] px;
  } mv_t;
  mv_t mv_tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // ---------------- driver tasks (all start and end on a negedge) ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; restart = 1'b0; left = 1'b0; right = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Inputs sampled on a tick are only changed outside tick cycles.
  task automatic set_ctrl(input logic s, input logic r);
    if (tick_a === 1'b1) @(negedge clk);
    start   = s;
    restart = r;
  endtask

  // Advance through the next tick and return once its update is visible.
  task automatic tick_step();
    int n;
    n = 0;
    @(negedge clk);
    while (tick_a !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (tick_a !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: no tick_o within 16 cycles");
    end
    tick_lfsr = m_lfsr;
    @(negedge clk);
  endtask

  task automatic pulse(input logic l, input logic r);
    left = l; right = r;
    repeat (2) @(negedge clk);
    left = 1'b0; right = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_tick_period(input string name);
    int n;
    int guard;
    guard = 0;
    while (tick_a !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick_a !== 1'b1 && n < 16);
    check(name, n, 4);
  endtask

  task automatic start_game();
    set_ctrl(1'b1, 1'b0);
    tick_step();
    set_ctrl(1'b0, 1'b0);
  endtask

  function automatic int clampy(input int v);
    return (v < 0) ? 0 : ((v > 12) ? 12 : v);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0]  lo, hi;
    logic [11:0] exp_obx;
    int          px_model;
    mv_t         v;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; restart = 1'b0; left = 1'b0; right = 1'b0;

    // 1: asynchronous reset in the middle of a game
    do_reset();
    start_game();
    check("start_state", state_a, 2'd1);
    pulse(1'b1, 1'b0);
    repeat (4) tick_step();
    check("pre_reset_px", px_a, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", state_a, 2'd0);
    check("rst_px",    px_a,    4'd8);
    check("rst_obx",   obx_a,   12'h741);
    check("rst_oby",   oby_a,   12'h000);
    check("rst_score", score_a, 8'd0);
    check("rst_tick",  tick_a,  1'b0);

    // 2: obstacle fall windows over the first 13 PLAY ticks
    do_reset();
    start_game();
    check("play_state", state_a, 2'd1);
    for (int t = 1; t <= 13; t++) begin
      exp_q.push_back(32'((clampy(t - 8) << 8) | (clampy(t - 4) << 4) | clampy(t - 1)));
      tick_step();
      sb_pop("ob_y_fall", oby_a);
    end

    // 3: player moves, clamping and simultaneous edges (table driven)
    do_reset();
    start_game();
    px_model = 8;
    for (int i = 0; i < 9; i++) begin
      px_model = (px_model > 0) ? px_model - 1 : 0;
      v.l = 1'b1; v.r = 1'b0; v.px = 4'(px_model);
      mv_tab.push_back(v);
    end
    for (int i = 0; i < 20; i++) begin
      px_model = (px_model < 15) ? px_model + 1 : 15;
      v.l = 1'b0; v.r = 1'b1; v.px = 4'(px_model);
      mv_tab.push_back(v);
    end
    v.l = 1'b1; v.r = 1'b1; v.px = 4'd15; mv_tab.push_back(v);
    v.l = 1'b1; v.r = 1'b0; v.px = 4'd14; mv_tab.push_back(v);
    v.l = 1'b1; v.r = 1'b1; v.px = 4'd14; mv_tab.push_back(v);
    v.l = 1'b0; v.r = 1'b1; v.px = 4'd15; mv_tab.push_back(v);
    foreach (mv_tab[i]) begin
      exp_q.push_back(32'(mv_tab[i].px));
      pulse(mv_tab[i].l, mv_tab[i].r);
      sb_pop("player_move", px_b);
    end

    // 4: collision with ob1 at row 10, frozen OVER, restart
    do_reset();
    start_game();
    repeat (7) pulse(1'b1, 1'b0);
    check("px_at_ob1", px_a, 4'd1);
    for (int i = 0; i < 20 && state_a !== 2'd2; i++) tick_step();
    check("hit_state", state_a, 2'd2);
    check("hit_oby",   oby_a,   12'h37A);
    set_ctrl(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick_step();
      check("over_state_hold", state_a, 2'd2);
      check("over_oby_hold",   oby_a,   12'h37A);
    end
    set_ctrl(1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    check("over_px_frozen", px_a, 4'd1);
    check_tick_period("tick_period_over");
    set_ctrl(1'b0, 1'b1);
    tick_step();
    set_ctrl(1'b0, 1'b0);
    check("restart_state", state_a, 2'd0);
    check("restart_oby",   oby_a,   12'h000);
    check("restart_px",    px_a,    4'd8);

    // 6: control priorities and tick period in IDLE and PLAY
    check_tick_period("tick_period_idle");
    set_ctrl(1'b0, 1'b1);
    tick_step();
    check("idle_restart_ignored", state_a, 2'd0);
    set_ctrl(1'b1, 1'b1);
    tick_step();
    check("idle_both_to_play", state_a, 2'd1);
    set_ctrl(1'b0, 1'b0);
    check_tick_period("tick_period_play");
    set_ctrl(1'b1, 1'b1);
    tick_step();
    set_ctrl(1'b0, 1'b0);
    check("play_both_to_idle", state_a, 2'd0);

    // 5: wave completion, new columns from the LFSR, score saturation
    do_reset();
    start_game();
    for (int w = 1; w <= 256; w++) begin
      for (int t = 1; t <= 21; t++) begin
        tick_step();
        if (w == 2 && t == 2) check("new_wave_oby", oby_b, 12'h001);
      end
      exp_q.push_back(32'((w > 255) ? 255 : w));
      sb_pop("wave_score", score_b);
      if (w <= 2) begin
        lo = tick_lfsr[3:0];
        hi = tick_lfsr[7:4];
        exp_obx = {lo ^ hi, hi, lo};
        check("wave_obx", obx_b, exp_obx);
        check("wave_oby", oby_b, 12'h000);
      end
    end
    check("sat_state", state_b, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
